// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared mode/location encodings and BCD digit limits for the clock
package clock_pkg;

  typedef enum logic [1:0] {
    SETUP   = 2'b00,
    TIME24  = 2'b01,
    SECONDS = 2'b10,
    TIME12  = 2'b11
  } modeT;

  typedef enum logic [1:0] {
    LOC_HU = 2'd0,
    LOC_HL = 2'd1,
    LOC_MU = 2'd2,
    LOC_ML = 2'd3
  } locT;

  // Largest legal value of each digit position
  localparam logic [1:0] HU_MAX       = 2'd2;
  localparam logic [3:0] HL_MAX_AT_20 = 4'd3;
  localparam logic [2:0] TENS_MAX     = 3'd5;
  localparam logic [3:0] UNITS_MAX    = 4'd9;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - button history register and single-cycle rising-edge pulse
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic btnQ;

  // Remember last sampled level so a held button yields one pulse only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btnQ <= 1'b0;
    else        btnQ <= btn;
  end

  assign rise = btn & ~btnQ;

endmodule

// File: rtl/time_setup_ctrl.sv
// rtl/time_setup_ctrl.sv - BCD timekeeping, 1 Hz prescaler and push-button time setting
module time_setup_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  output logic [1:0] mode,
  output logic [1:0] location,
  output logic [3:0] secondsLower,
  output logic [2:0] secondsUpper,
  output logic [3:0] minutesLower,
  output logic [2:0] minutesUpper,
  output logic [3:0] hoursLower,
  output logic [1:0] hoursUpper,
  output logic       blink
);

  localparam int               CNT_W    = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_HZ / 2 - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             modeEvt, nextEvt, incEvt;
  logic             enterSetup;
  modeT             modeQ, modeD;
  locT              locQ, locD;
  logic [3:0]       secLD, minLD, hrLD;
  logic [2:0]       secUD, minUD;
  logic [1:0]       hrUD;

  btn_edge uModeEdge (.clk(clk), .rst_n(rst_n), .btn(btn_mode), .rise(modeEvt));
  btn_edge uNextEdge (.clk(clk), .rst_n(rst_n), .btn(btn_next), .rise(nextEvt));
  btn_edge uIncEdge  (.clk(clk), .rst_n(rst_n), .btn(btn_inc),  .rise(incEvt));

  assign tick       = (cnt == CNT_LAST);
  assign enterSetup = modeEvt && (modeQ == TIME12);

  // Free-running prescaler; blink flips at the half and full second
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      blink <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (cnt == CNT_HALF || tick) blink <= ~blink;
    end
  end

  // Mode state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) modeQ <= SETUP;
    else        modeQ <= modeD;
  end

  // Mode next state: each mode press steps forward, wrapping TIME12 to SETUP
  always_comb begin
    modeD = modeQ;
    if (modeEvt) modeD = modeT'(modeQ + 2'd1);
  end

  // Mode/location outputs straight from registers
  always_comb begin
    mode     = modeQ;
    location = locQ;
  end

  // Next time/location: running tick carry chain, then setup edits
  always_comb begin
    secLD = secondsLower;
    secUD = secondsUpper;
    minLD = minutesLower;
    minUD = minutesUpper;
    hrLD  = hoursLower;
    hrUD  = hoursUpper;
    locD  = locQ;
    if (modeQ != SETUP && tick) begin
      if (secondsLower == UNITS_MAX) begin
        secLD = '0;
        if (secondsUpper == TENS_MAX) begin
          secUD = '0;
          if (minutesLower == UNITS_MAX) begin
            minLD = '0;
            if (minutesUpper == TENS_MAX) begin
              minUD = '0;
              if (hoursUpper == HU_MAX && hoursLower == HL_MAX_AT_20) begin
                hrUD = '0;
                hrLD = '0;
              end else if (hoursLower == UNITS_MAX) begin
                hrLD = '0;
                hrUD = hoursUpper + 2'd1;
              end else begin
                hrLD = hoursLower + 4'd1;
              end
            end else begin
              minUD = minutesUpper + 3'd1;
            end
          end else begin
            minLD = minutesLower + 4'd1;
          end
        end else begin
          secUD = secondsUpper + 3'd1;
        end
      end else begin
        secLD = secondsLower + 4'd1;
      end
    end
    if (enterSetup) begin
      // Seconds clear overrides a coincident tick, so nothing carries upward
      secLD = '0;
      secUD = '0;
      minLD = minutesLower;
      minUD = minutesUpper;
      hrLD  = hoursLower;
      hrUD  = hoursUpper;
      locD  = LOC_HU;
    end else if (modeQ == SETUP && !modeEvt) begin
      if (incEvt) begin
        case (locQ)
          LOC_HU: begin
            if (hoursUpper == HU_MAX) begin
              hrUD = '0;
            end else begin
              hrUD = hoursUpper + 2'd1;
              if (hoursUpper == HU_MAX - 2'd1 && hoursLower > HL_MAX_AT_20) hrLD = HL_MAX_AT_20;
            end
          end
          LOC_HL: begin
            if (hoursLower >= UNITS_MAX || (hoursUpper == HU_MAX && hoursLower >= HL_MAX_AT_20))
              hrLD = '0;
            else
              hrLD = hoursLower + 4'd1;
          end
          LOC_MU:  minUD = (minutesUpper >= TENS_MAX) ? 3'd0 : minutesUpper + 3'd1;
          LOC_ML:  minLD = (minutesLower >= UNITS_MAX) ? 4'd0 : minutesLower + 4'd1;
          default: ;
        endcase
      end
      // Increment above used the old location; advance afterwards
      if (nextEvt) locD = locT'(locQ + 2'd1);
    end
  end

  // Time digits and setup location registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      secondsLower <= '0;
      secondsUpper <= '0;
      minutesLower <= '0;
      minutesUpper <= '0;
      hoursLower   <= '0;
      hoursUpper   <= '0;
      locQ         <= LOC_HU;
    end else begin
      secondsLower <= secLD;
      secondsUpper <= secUD;
      minutesLower <= minLD;
      minutesUpper <= minUD;
      hoursLower   <= hrLD;
      hoursUpper   <= hrUD;
      locQ         <= locD;
    end
  end

endmodule

// File: tb/tb_time_setup_ctrl.sv
// tb/tb_time_setup_ctrl.sv - directed self-checking bench for time_setup_ctrl at CLK_HZ=8
module tb_time_setup_ctrl;

  localparam int HZ = 8;
  localparam int P_MODE = 0;
  localparam int P_NEXT = 1;
  localparam int P_INC  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btnMode = 1'b0, btnNext = 1'b0, btnInc = 1'b0;
  logic [1:0] mode, location, hoursUpper;
  logic [3:0] secondsLower, minutesLower, hoursLower;
  logic [2:0] secondsUpper, minutesUpper;
  logic       blink;
  int         compared = 0;
  int         mismatched = 0;
  int         edges;
  logic [19:0] timeNow;

  assign timeNow = {hoursUpper, hoursLower, minutesUpper, minutesLower, secondsUpper, secondsLower};

  time_setup_ctrl #(.CLK_HZ(HZ)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_mode(btnMode), .btn_next(btnNext), .btn_inc(btnInc),
    .mode(mode), .location(location),
    .secondsLower(secondsLower), .secondsUpper(secondsUpper),
    .minutesLower(minutesLower), .minutesUpper(minutesUpper),
    .hoursLower(hoursLower), .hoursUpper(hoursUpper),
    .blink(blink)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; prescaler count equals edges % HZ
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  function automatic logic [19:0] mk(input int hu, input int hl, input int mu,
                                     input int ml, input int su, input int sl);
    return {hu[1:0], hl[3:0], mu[2:0], ml[3:0], su[2:0], sl[3:0]};
  endfunction

  function automatic string hms(input logic [19:0] v);
    return $sformatf("%0d%0d:%0d%0d:%0d%0d", v[19:18], v[17:14], v[13:11], v[10:7], v[6:4], v[3:0]);
  endfunction

  task automatic doReset();
    btnMode = 1'b0; btnNext = 1'b0; btnInc = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse(input int which);
    btnMode = (which == P_MODE);
    btnNext = (which == P_NEXT);
    btnInc  = (which == P_INC);
    @(posedge clk); #1;
    btnMode = 1'b0; btnNext = 1'b0; btnInc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic waitEdges(input int n);
    while (edges < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic alignTick();
    do begin
      @(posedge clk); #1;
    end while (edges % HZ != 0);
  endtask

  task automatic waitTicks(input int n);
    repeat (n) alignTick();
  endtask

  task automatic setHM(input int hu, input int hl, input int mu, input int ml);
    repeat (hu) pulse(P_INC);
    pulse(P_NEXT);
    repeat (hl) pulse(P_INC);
    pulse(P_NEXT);
    repeat (mu) pulse(P_INC);
    pulse(P_NEXT);
    repeat (ml) pulse(P_INC);
    pulse(P_NEXT);
  endtask

  task automatic test_reset();
    doReset();
    #1;
    compared++;
    if (mode !== 2'd0) begin mismatched++; $display("FAIL reset_mode: got %0d want 0", mode); end
    compared++;
    if (location !== 2'd0) begin mismatched++; $display("FAIL reset_location: got %0d want 0", location); end
    compared++;
    if (timeNow !== 20'd0) begin mismatched++; $display("FAIL reset_time: got %s want 00:00:00", hms(timeNow)); end
    compared++;
    if (blink !== 1'b0) begin mismatched++; $display("FAIL reset_blink: got %0b want 0", blink); end
  endtask

  task automatic test_setup_entry();
    doReset();
    pulse(P_NEXT);
    pulse(P_INC);
    compared++;
    if (timeNow !== mk(0, 1, 0, 0, 0, 0)) begin mismatched++; $display("FAIL setup_hl_inc: got %s want 01:00:00", hms(timeNow)); end
    compared++;
    if (location !== 2'd1) begin mismatched++; $display("FAIL setup_location: got %0d want 1", location); end
    repeat (8) pulse(P_INC);
    repeat (3) pulse(P_NEXT);
    compared++;
    if (location !== 2'd0) begin mismatched++; $display("FAIL setup_loc_wrap: got %0d want 0", location); end
    pulse(P_INC);
    compared++;
    if (timeNow !== mk(1, 9, 0, 0, 0, 0)) begin mismatched++; $display("FAIL setup_19: got %s want 19:00:00", hms(timeNow)); end
    pulse(P_INC);
    compared++;
    if (timeNow !== mk(2, 3, 0, 0, 0, 0)) begin mismatched++; $display("FAIL setup_clamp: got %s want 23:00:00", hms(timeNow)); end
    pulse(P_NEXT);
    pulse(P_INC);
    compared++;
    if (timeNow !== mk(2, 0, 0, 0, 0, 0)) begin mismatched++; $display("FAIL setup_hl_wrap3: got %s want 20:00:00", hms(timeNow)); end
    pulse(P_NEXT);
    repeat (6) pulse(P_INC);
    compared++;
    if (timeNow !== mk(2, 0, 0, 0, 0, 0)) begin mismatched++; $display("FAIL setup_mu_wrap5: got %s want 20:00:00", hms(timeNow)); end
    repeat (40) @(posedge clk);
    #1;
    compared++;
    if (timeNow !== mk(2, 0, 0, 0, 0, 0)) begin mismatched++; $display("FAIL setup_frozen: got %s want 20:00:00", hms(timeNow)); end
    compared++;
    if (mode !== 2'd0) begin mismatched++; $display("FAIL setup_mode: got %0d want 0", mode); end
  endtask

  task automatic test_rollover();
    doReset();
    setHM(2, 3, 5, 9);
    compared++;
    if (timeNow !== mk(2, 3, 5, 9, 0, 0)) begin mismatched++; $display("FAIL roll_set: got %s want 23:59:00", hms(timeNow)); end
    alignTick();
    pulse(P_MODE);
    compared++;
    if (mode !== 2'd1) begin mismatched++; $display("FAIL roll_mode: got %0d want 1", mode); end
    waitTicks(59);
    compared++;
    if (timeNow !== mk(2, 3, 5, 9, 5, 9)) begin mismatched++; $display("FAIL roll_235959: got %s want 23:59:59", hms(timeNow)); end
    waitTicks(1);
    compared++;
    if (timeNow !== 20'd0) begin mismatched++; $display("FAIL roll_wrap: got %s want 00:00:00", hms(timeNow)); end
  endtask

  task automatic test_carry();
    doReset();
    setHM(0, 9, 5, 9);
    alignTick();
    pulse(P_MODE);
    waitTicks(59);
    compared++;
    if (timeNow !== mk(0, 9, 5, 9, 5, 9)) begin mismatched++; $display("FAIL carry_095959: got %s want 09:59:59", hms(timeNow)); end
    waitTicks(1);
    compared++;
    if (timeNow !== mk(1, 0, 0, 0, 0, 0)) begin mismatched++; $display("FAIL carry_100000: got %s want 10:00:00", hms(timeNow)); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (mode !== 2'd0) begin mismatched++; $display("FAIL areset_mode: got %0d want 0", mode); end
    compared++;
    if (timeNow !== 20'd0) begin mismatched++; $display("FAIL areset_time: got %s want 00:00:00", hms(timeNow)); end
    doReset();
  endtask

  task automatic test_priority();
    doReset();
    pulse(P_NEXT);
    pulse(P_INC);
    btnMode = 1'b1; btnNext = 1'b1; btnInc = 1'b1;
    @(posedge clk); #1;
    btnMode = 1'b0; btnNext = 1'b0; btnInc = 1'b0;
    compared++;
    if (mode !== 2'd1) begin mismatched++; $display("FAIL prio_mode: got %0d want 1", mode); end
    compared++;
    if (location !== 2'd1) begin mismatched++; $display("FAIL prio_location: got %0d want 1", location); end
    compared++;
    if (timeNow !== mk(0, 1, 0, 0, 0, 0)) begin mismatched++; $display("FAIL prio_digits: got %s want 01:00:00", hms(timeNow)); end
    @(posedge clk); #1;
    repeat (3) pulse(P_MODE);
    compared++;
    if (mode !== 2'd0) begin mismatched++; $display("FAIL prio_back_setup: got %0d want 0", mode); end
    compared++;
    if (location !== 2'd0) begin mismatched++; $display("FAIL prio_loc_cleared: got %0d want 0", location); end
    compared++;
    if (timeNow !== mk(0, 1, 0, 0, 0, 0)) begin mismatched++; $display("FAIL prio_sec_cleared: got %s want 01:00:00", hms(timeNow)); end
    btnInc = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    btnInc = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (timeNow !== mk(1, 1, 0, 0, 0, 0)) begin mismatched++; $display("FAIL held_inc_once: got %s want 11:00:00", hms(timeNow)); end
  endtask

  task automatic test_blink();
    doReset();
    btnMode = 1'b1;
    @(posedge clk); #1;
    btnMode = 1'b0;
    compared++;
    if (mode !== 2'd1) begin mismatched++; $display("FAIL blink_mode: got %0d want 1", mode); end
    waitEdges(3);
    compared++;
    if (blink !== 1'b0) begin mismatched++; $display("FAIL blink_e3: got %0b want 0", blink); end
    waitEdges(4);
    compared++;
    if (blink !== 1'b1) begin mismatched++; $display("FAIL blink_e4: got %0b want 1", blink); end
    waitEdges(7);
    compared++;
    if (timeNow !== 20'd0) begin mismatched++; $display("FAIL tick_not_yet: got %s want 00:00:00", hms(timeNow)); end
    waitEdges(8);
    compared++;
    if (blink !== 1'b0) begin mismatched++; $display("FAIL blink_e8: got %0b want 0", blink); end
    compared++;
    if (timeNow !== mk(0, 0, 0, 0, 0, 1)) begin mismatched++; $display("FAIL tick_first: got %s want 00:00:01", hms(timeNow)); end
    waitEdges(12);
    compared++;
    if (blink !== 1'b1) begin mismatched++; $display("FAIL blink_e12: got %0b want 1", blink); end
    waitEdges(16);
    compared++;
    if (timeNow !== mk(0, 0, 0, 0, 0, 2)) begin mismatched++; $display("FAIL tick_second: got %s want 00:00:02", hms(timeNow)); end
    pulse(P_MODE);
    pulse(P_MODE);
    waitEdges(59 * HZ);
    compared++;
    if (timeNow !== mk(0, 0, 0, 0, 5, 9)) begin mismatched++; $display("FAIL time12_count: got %s want 00:00:59", hms(timeNow)); end
    compared++;
    if (mode !== 2'd3) begin mismatched++; $display("FAIL time12_mode: got %0d want 3", mode); end
    waitEdges(60 * HZ - 1);
    btnMode = 1'b1;
    @(posedge clk); #1;
    btnMode = 1'b0;
    compared++;
    if (mode !== 2'd0) begin mismatched++; $display("FAIL coinc_mode: got %0d want 0", mode); end
    compared++;
    if (timeNow !== 20'd0) begin mismatched++; $display("FAIL coinc_clear: got %s want 00:00:00", hms(timeNow)); end
  endtask

  initial begin
    test_reset();
    test_setup_entry();
    test_rollover();
    test_carry();
    test_async_reset();
    test_priority();
    test_blink();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
